// File: rtl/motor_ramp_ctrl_if.sv
// Speed-command handshake between a command source and one motor_ramp_ctrl channel.
interface motor_ramp_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [13:0] cmd_mag;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_mag,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_mag,
        output cmd_ready
    );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Slew-rate and direction sequencer feeding the 14-bit motor PWM duty word.
// Ramps vq toward the commanded magnitude in STEP increments once per ramp
// tick, forces every reversal through zero duty plus a dead time, and lets
// estop override everything.
module motor_ramp_ctrl #(
    parameter logic [13:0] STEP     = 14'd64,
    parameter int unsigned RAMP_DIV = 1000,
    parameter int unsigned DEAD_CYC = 5000,
    parameter logic [13:0] VQ_MAX   = 14'd16383
) (
    input  logic                    clk,
    input  logic                    rst,
    motor_ramp_ctrl_if.slave        cmd,
    input  logic                    estop,
    output logic [13:0]             vq,
    output logic                    dir,
    output logic                    busy,
    output logic                    at_target
);

    localparam int unsigned     PW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned     DW        = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(RAMP_DIV - 1);
    localparam logic [PW-1:0]   PRE_ONE   = PW'(1);
    localparam logic [DW-1:0]   DEAD_LOAD = DW'(DEAD_CYC - 1);
    localparam logic [DW-1:0]   DEAD_ONE  = DW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DEAD = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t        state_r, state_n_s;
    logic [13:0]   vq_r, vq_n_s;
    logic          dir_r, dir_n_s;
    logic [13:0]   tgt_mag_r, tgt_mag_n_s;
    logic          tgt_dir_r, tgt_dir_n_s;
    logic [DW-1:0] dead_r, dead_n_s;
    logic [PW-1:0] pre_r;
    logic          busy_r, busy_n_s;
    logic          at_target_r, at_target_n_s;
    logic          tick_s;
    logic          accept_s;
    logic [13:0]   mag_clamped_s;

    // Limit a requested magnitude to the duty ceiling.
    function automatic logic [13:0] clamp_mag(input logic [13:0] mag);
        logic [13:0] res_s;
        if (mag > VQ_MAX) begin
            res_s = VQ_MAX;
        end else begin
            res_s = mag;
        end
        return res_s;
    endfunction

    // One deceleration step toward zero, never going below zero.
    function automatic logic [13:0] step_down(input logic [13:0] cur);
        logic [13:0] res_s;
        if (cur > STEP) begin
            res_s = cur - STEP;
        end else begin
            res_s = 14'd0;
        end
        return res_s;
    endfunction

    // One step toward tgt, landing exactly on tgt; the upward sum is
    // formed in 15 bits so a large STEP can never wrap past full scale.
    function automatic logic [13:0] step_toward(input logic [13:0] cur, input logic [13:0] tgt);
        logic [14:0] up_s;
        logic [13:0] res_s;
        up_s = {1'b0, cur} + {1'b0, STEP};
        if (cur < tgt) begin
            if (up_s > {1'b0, tgt}) begin
                res_s = tgt;
            end else begin
                res_s = up_s[13:0];
            end
        end else if ((cur - tgt) > STEP) begin
            res_s = cur - STEP;
        end else begin
            res_s = tgt;
        end
        return res_s;
    endfunction

    assign tick_s        = (pre_r == PRE_LAST);
    assign cmd.cmd_ready = !estop;
    assign accept_s      = cmd.cmd_valid && !estop;
    assign mag_clamped_s = clamp_mag(cmd.cmd_mag);

    assign vq        = vq_r;
    assign dir       = dir_r;
    assign busy      = busy_r;
    assign at_target = at_target_r;

    // Free-running ramp-tick prescaler; commands never realign it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= '0;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= '0;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    // Next-state logic: estop first, then the ramp/dead sequencing on the
    // current target, then a newly accepted command retargets for next cycle.
    always_comb begin
        state_n_s   = state_r;
        vq_n_s      = vq_r;
        dir_n_s     = dir_r;
        tgt_mag_n_s = tgt_mag_r;
        tgt_dir_n_s = tgt_dir_r;
        dead_n_s    = dead_r;
        if (estop) begin
            vq_n_s      = 14'd0;
            tgt_mag_n_s = 14'd0;
            state_n_s   = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_n_s = ST_IDLE;
                end
                ST_RAMP: begin
                    if (dir_r != tgt_dir_r) begin
                        if (vq_r == 14'd0) begin
                            state_n_s = ST_DEAD;
                            dead_n_s  = DEAD_LOAD;
                        end else if (tick_s) begin
                            vq_n_s = step_down(vq_r);
                            // Entering DEAD on the step that reaches zero keeps
                            // the zero-duty window exactly the dead time long.
                            if (vq_n_s == 14'd0) begin
                                state_n_s = ST_DEAD;
                                dead_n_s  = DEAD_LOAD;
                            end else begin
                                state_n_s = ST_RAMP;
                            end
                        end else begin
                            state_n_s = ST_RAMP;
                        end
                    end else begin
                        if (tick_s) begin
                            vq_n_s = step_toward(vq_r, tgt_mag_r);
                        end else begin
                            vq_n_s = vq_r;
                        end
                        if (vq_n_s == tgt_mag_r) begin
                            state_n_s = (tgt_mag_r == 14'd0) ? ST_IDLE : ST_HOLD;
                        end else begin
                            state_n_s = ST_RAMP;
                        end
                    end
                end
                ST_DEAD: begin
                    vq_n_s = 14'd0;
                    if (dead_r == '0) begin
                        dir_n_s   = tgt_dir_r;
                        state_n_s = ST_RAMP;
                    end else begin
                        dead_n_s  = dead_r - DEAD_ONE;
                    end
                end
                ST_HOLD: begin
                    state_n_s = ST_HOLD;
                end
                default: begin
                    vq_n_s    = 14'd0;
                    state_n_s = ST_IDLE;
                end
            endcase
            if (accept_s) begin
                tgt_mag_n_s = mag_clamped_s;
                // A zero-speed command never requests a reversal.
                if (mag_clamped_s == 14'd0) begin
                    tgt_dir_n_s = tgt_dir_r;
                end else begin
                    tgt_dir_n_s = cmd.cmd_dir;
                end
                if (((state_n_s == ST_IDLE) || (state_n_s == ST_HOLD)) &&
                    ((mag_clamped_s != vq_n_s) || (tgt_dir_n_s != dir_n_s))) begin
                    state_n_s = ST_RAMP;
                end else begin
                    state_n_s = state_n_s;
                end
            end else begin
                tgt_dir_n_s = tgt_dir_n_s;
            end
        end
    end

    // Status flags decoded from next-state values so they register in step with vq.
    always_comb begin
        busy_n_s      = (state_n_s == ST_RAMP) || (state_n_s == ST_DEAD);
        at_target_n_s = (vq_n_s == tgt_mag_n_s) &&
                        ((dir_n_s == tgt_dir_n_s) || (tgt_mag_n_s == 14'd0)) &&
                        (state_n_s != ST_DEAD);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            vq_r        <= 14'd0;
            dir_r       <= 1'b1;
            tgt_mag_r   <= 14'd0;
            tgt_dir_r   <= 1'b1;
            dead_r      <= '0;
            busy_r      <= 1'b0;
            at_target_r <= 1'b1;
        end else begin
            state_r     <= state_n_s;
            vq_r        <= vq_n_s;
            dir_r       <= dir_n_s;
            tgt_mag_r   <= tgt_mag_n_s;
            tgt_dir_r   <= tgt_dir_n_s;
            dead_r      <= dead_n_s;
            busy_r      <= busy_n_s;
            at_target_r <= at_target_n_s;
        end
    end

endmodule
